// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI configuration target
package spi_pkg;

   // Frame geometry: R/W bit, 7-bit address, 8-bit data, MSB first
   localparam int FRAME_BITS = 16;
   localparam int ADDR_W     = 7;

   // Receive state machine encoding
   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      SHIFT     = 2'd2,
      FULL      = 2'd3
   } spi_state_e;

   // Register map
   localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - pin synchronizer with delay flop and edge detect
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              dly_q;

   // Shift the asynchronous pin through the synchronizer chain, then one delay flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         dly_q  <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~dly_q;
   assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - write-only mode-0 SPI target feeding the PWM configuration registers
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_REGS    = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe
);

   localparam logic [1:0] S_WAIT_IDLE = WAIT_IDLE;
   localparam logic [1:0] S_IDLE      = IDLE;
   localparam logic [1:0] S_SHIFT     = SHIFT;
   localparam logic [1:0] S_FULL      = FULL;

   localparam logic [4:0]      LAST_BIT    = 5'(FRAME_BITS - 1);
   localparam logic [ADDR_W:0] NUM_REGS_W  = NUM_REGS[ADDR_W:0];

   logic sclk_level_unused, sclk_rise, sclk_fall_unused;
   logic copi_level, copi_rise_unused, copi_fall_unused;
   logic ncs_level, ncs_rise, ncs_fall;

   logic [1:0]            state;
   logic [4:0]            bit_cnt;
   logic [FRAME_BITS-1:0] shreg;
   logic [ADDR_W-1:0]     frame_addr;
   logic [7:0]            frame_data;
   logic                  commit;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .din(sclk),
      .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_copi (
      .clk(clk), .rst_n(rst_n), .din(copi),
      .level(copi_level), .rise(copi_rise_unused), .fall(copi_fall_unused)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
      .clk(clk), .rst_n(rst_n), .din(ncs),
      .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
   );

   assign frame_addr = shreg[FRAME_BITS-2 -: ADDR_W];
   assign frame_data = shreg[7:0];

   // A complete write frame to an implemented address commits on the ncs rise
   assign commit = (state == S_FULL) && ncs_rise && shreg[FRAME_BITS-1]
                   && ({1'b0, frame_addr} < NUM_REGS_W);

   // Frame receive FSM: ncs rise always returns to IDLE, leaving a short frame uncommitted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_WAIT_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            S_WAIT_IDLE: begin
               if (ncs_level) state <= S_IDLE;
            end
            S_IDLE: begin
               if (ncs_fall) begin
                  state   <= S_SHIFT;
                  bit_cnt <= '0;
                  shreg   <= '0;
               end
            end
            S_SHIFT: begin
               if (ncs_rise) begin
                  state <= S_IDLE;
               end else if (sclk_rise) begin
                  shreg   <= {shreg[FRAME_BITS-2:0], copi_level};
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == LAST_BIT) state <= S_FULL;
               end
            end
            default: begin
               if (ncs_rise) state <= S_IDLE;
            end
         endcase
      end
   end

   // Configuration registers hold until a committed write to their own address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_reg_out_7_0  <= 8'h00;
         en_reg_out_15_8 <= 8'h00;
         en_reg_pwm_7_0  <= 8'h00;
         en_reg_pwm_15_8 <= 8'h00;
         pwm_duty_cycle  <= 8'h00;
         wr_strobe       <= 1'b0;
      end else begin
         wr_strobe <= commit;
         if (commit) begin
            case (frame_addr)
               ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
               ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
               ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
               ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
               ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

- Write-only SPI target (mode 0) that configures the PWM output block.
- Receives 16-bit frames on three chip pins: SCLK, COPI and nCS.
- Decodes the address and updates the five 8-bit configuration registers that feed `pwm_peripheral`.
- Sits in the top level between `ui_in[2:0]` and the PWM enable/duty inputs. All SPI pins are asynchronous to `clk` and are oversampled.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for sclk, copi and ncs (minimum 2).
- `NUM_REGS`, default 5: number of implemented register addresses, starting at 0x00.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `sclk` in 1: SPI clock, idle low.
- `copi` in 1: SPI data, MSB first.
- `ncs` in 1: SPI chip select, active-low.
- `en_reg_out_7_0` out 8: output enables for outputs 7:0.
- `en_reg_out_15_8` out 8: output enables for outputs 15:8.
- `en_reg_pwm_7_0` out 8: PWM-mode enables for outputs 7:0.
- `en_reg_pwm_15_8` out 8: PWM-mode enables for outputs 15:8.
- `pwm_duty_cycle` out 8: shared duty cycle, in 1/256 steps.
- `wr_strobe` out 1: one-cycle pulse when a register is written.

## Operation
Frame format, 16 bits, MSB first:
- bit15 = R/W̄; 1 = write, 0 = read, which is discarded.
- bits14:8 = address.
- bits7:0 = data.

Register map:
- 0x00 → `en_reg_out_7_0`
- 0x01 → `en_reg_out_15_8`
- 0x02 → `en_reg_pwm_7_0`
- 0x03 → `en_reg_pwm_15_8`
- 0x04 → `pwm_duty_cycle`
- 0x05–0x7F: writes ignored, no strobe.

Synchronization and sampling:
- Each pin passes through `SYNC_STAGES` flops, plus one delay flop for edge detect.
- Data is shifted on the rising edge of synchronized sclk, sampling synchronized copi.
- Falling sclk edges are ignored.

State machine:
- WAIT_IDLE (reset state) → IDLE when synchronized ncs = 1. This blocks half-frames that are in flight when reset releases.
- IDLE → SHIFT on a synced ncs falling edge; clears the bit counter (5 bits) and the shift register (16 bits).
- SHIFT: each sclk rising edge shifts in one bit and increments the counter. At count 16 → FULL.
- FULL: further sclk edges are ignored; the first 16 bits are kept.
- SHIFT or FULL → IDLE on a synced ncs rising edge. A commit happens only if all of these hold:
  - state was FULL;
  - bit15 = 1;
  - address < `NUM_REGS`.
- An ncs rise with count < 16 discards the frame.

Commit:
- Writes data to the addressed register.
- Pulses `wr_strobe` for one cycle.

Reset:
- All outputs = 0x00, `wr_strobe` = 0.
- Synchronizers reset as follows: sclk 0, copi 0, ncs 0. Because ncs resets to 0, the machine must see ncs = 1 before leaving WAIT_IDLE.
- Assertion mid-frame aborts the frame; no partial write occurs.

## Timing
- A pin change first sampled at clk edge k appears at the synchronizer output after edge k+SYNC_STAGES−1. The edge is detected in the following cycle.
- With the default depth:
  - an ncs rise sampled at edge k produces the register update and the `wr_strobe` assertion at edge k+2;
  - `wr_strobe` deasserts at edge k+3.
- Register outputs hold their value until the next committed write to the same address or reset. There is no glitching between commits.
- Required SPI timing:
  - sclk high time and low time ≥ SYNC_STAGES+1 clk periods each;
  - copi stable from 1 clk before to SYNC_STAGES+1 clk after the sclk rise;
  - ncs high time between frames ≥ SYNC_STAGES+1 clk.
- Back-to-back frames that meet the minimum ncs high time are all committed.
- If the ncs rise and the 16th sclk rise are detected in the same cycle, the ncs rise wins, count < 16, and the frame is discarded. Hosts must respect the setup time.

## Structure
Shared package `spi_pkg` contains:
- state enum {WAIT_IDLE, IDLE, SHIFT, FULL};
- `FRAME_BITS` = 16;
- `ADDR_W` = 7;
- address constants `ADDR_EN_OUT_LO`/`HI`, `ADDR_EN_PWM_LO`/`HI`, `ADDR_DUTY`.

One sub-module, `spi_sync_edge`: parameterized synchronizer plus delay flop, with outputs `level`, `rise` and `fall`. It is instantiated three times, once each for sclk, copi and ncs.

## Test plan
- Write frame 0x80F0 (write, addr 0x00, data 0xF0) → `en_reg_out_7_0` = 0xF0 two clocks after the ncs rise, one `wr_strobe` pulse, other registers remain 0x00.
- Write 0x8480 → `pwm_duty_cycle` = 0x80; then read frame 0x04FF → duty stays 0x80, no strobe.
- Write to addr 0x05 (0x8555) and addr 0x7F → no register changes, no strobe.
- Truncated frame: 10 bits, then ncs rise → ignored. A 20-bit frame 0x82AA + 4 extra bits → `en_reg_pwm_7_0` = 0xAA.
- Assert `rst_n` after bit 8 of 0x81FF with ncs held low, release, then finish the frame → outputs 0x00, no commit. The next full frame commits normally.
- Five back-to-back writes, one per address, at minimum sclk and ncs timing → all five registers hold their written values and five strobes are seen.
